// File: rtl/gun_fire_controller.sv
// gun_fire_controller
//   Consumer side of the gun heat interface. Decides when a bullet may be
//   fired, issues valid/ready spawn requests to the bullet manager, enforces
//   a minimum inter-shot gap and an overheat lockout with hysteresis, and
//   drives the cooldown handler's shoot input.
//
//   Build option: GUN_AUTOFIRE_EN
//     defined   -> holding trigger refires every gap (level-sensitive)
//     undefined -> one shot per trigger press (rising edge, not queued)
//
// Ports
//   clock        in   system clock
//   reset        in   synchronous, active-high
//   trigger      in   fire request, pre-synchronised
//   heat_level   in   current heat count from the cooldown handler
//   spawn_ready  in   bullet manager can accept a spawn
//   spawn_valid  out  spawn request; transfer when valid & ready
//   shoot_out    out  to the cooldown handler's shoot input
//   overheated   out  high while locked out
//   shots_fired  out  accepted-shot count, saturating at 255
module gun_fire_controller #(
    parameter int unsigned HEAT_W       = 4,
    parameter int unsigned HEAT_MAX     = 15,
    parameter int unsigned RESUME_LEVEL = 4,
    parameter int unsigned SHOT_GAP     = 25_000_000,
    parameter int unsigned GAP_W        = 28
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              trigger,
    input  logic [HEAT_W-1:0] heat_level,
    input  logic              spawn_ready,
    output logic              spawn_valid,
    output logic              shoot_out,
    output logic              overheated,
    output logic [7:0]        shots_fired
);

    localparam logic [HEAT_W-1:0] HEAT_MAX_V   = HEAT_W'(HEAT_MAX);
    localparam logic [HEAT_W-1:0] RESUME_V     = HEAT_W'(RESUME_LEVEL);
    localparam logic [GAP_W-1:0]  GAP_RELOAD   = GAP_W'(SHOT_GAP - 1);
    localparam logic [7:0]        SHOTS_SAT    = 8'hFF;

    typedef enum logic [1:0] {
        S_READY,
        S_SPAWN,
        S_GAP,
        S_LOCKOUT
    } state_t;

    state_t             state_q, state_d;
    logic               spawn_valid_q, spawn_valid_d;
    logic               shoot_out_q, shoot_out_d;
    logic               overheated_q, overheated_d;
    logic [7:0]         shots_fired_q, shots_fired_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic               fire_req;
    logic               heat_hot;
    logic               heat_cool;

    assign heat_hot  = (heat_level >= HEAT_MAX_V);
    assign heat_cool = (heat_level <= RESUME_V);

`ifdef GUN_AUTOFIRE_EN
    // Level-sensitive: a held trigger re-requests as soon as READY is reached.
    assign fire_req = trigger;
`else
    // Edge register tracks trigger in every state, so an edge seen outside
    // READY is consumed and lost rather than queued.
    logic trigger_prev_q, trigger_prev_d;

    assign trigger_prev_d = trigger;
    assign fire_req       = trigger & ~trigger_prev_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            trigger_prev_q <= 1'b0;
        end else begin
            trigger_prev_q <= trigger_prev_d;
        end
    end
`endif

    // State and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= S_READY;
            spawn_valid_q <= 1'b0;
            shoot_out_q   <= 1'b0;
            overheated_q  <= 1'b0;
            shots_fired_q <= 8'd0;
            gap_q         <= '0;
        end else begin
            state_q       <= state_d;
            spawn_valid_q <= spawn_valid_d;
            shoot_out_q   <= shoot_out_d;
            overheated_q  <= overheated_d;
            shots_fired_q <= shots_fired_d;
            gap_q         <= gap_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d       = state_q;
        spawn_valid_d = spawn_valid_q;
        overheated_d  = overheated_q;
        shots_fired_d = shots_fired_q;
        gap_d         = gap_q;

        unique case (state_q)
            S_READY: begin
                // Overheat check outranks a pending fire request.
                if (heat_hot) begin
                    state_d      = S_LOCKOUT;
                    overheated_d = 1'b1;
                end else if (fire_req) begin
                    state_d       = S_SPAWN;
                    spawn_valid_d = 1'b1;
                end
            end
            S_SPAWN: begin
                // Request is never withdrawn; only a transfer ends it.
                if (spawn_valid_q && spawn_ready) begin
                    state_d       = S_GAP;
                    spawn_valid_d = 1'b0;
                    gap_d         = GAP_RELOAD;
                    if (shots_fired_q != SHOTS_SAT) begin
                        shots_fired_d = shots_fired_q + 8'd1;
                    end
                end
            end
            S_GAP: begin
                if (gap_q == '0) begin
                    if (heat_hot) begin
                        state_d      = S_LOCKOUT;
                        overheated_d = 1'b1;
                    end else begin
                        state_d = S_READY;
                    end
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            S_LOCKOUT: begin
                spawn_valid_d = 1'b0;
                if (heat_cool) begin
                    state_d      = S_READY;
                    overheated_d = 1'b0;
                end
            end
            default: begin
                state_d       = S_READY;
                spawn_valid_d = 1'b0;
                overheated_d  = 1'b0;
            end
        endcase
    end

    // Using the next state forces shoot_out low on the very edge that enters
    // LOCKOUT, so the cooldown handler starts cooling immediately.
    assign shoot_out_d = trigger && (state_d != S_LOCKOUT);

    assign spawn_valid = spawn_valid_q;
    assign shoot_out   = shoot_out_q;
    assign overheated  = overheated_q;
    assign shots_fired = shots_fired_q;

endmodule

// File: tb/tb_gun_fire_controller.sv
// Testbench for gun_fire_controller (SHOT_GAP overridden to 4).
// A behavioural model tracks pending request, remaining wait cycles, lockout
// flag and shot count; every cycle all four outputs are compared with it.
module tb_gun_fire_controller;

    localparam int unsigned SHOT_GAP     = 4;
    localparam int unsigned HEAT_MAX     = 15;
    localparam int unsigned RESUME_LEVEL = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic       trigger;
    logic [3:0] heat_level;
    logic       spawn_ready;
    logic       spawn_valid;
    logic       shoot_out;
    logic       overheated;
    logic [7:0] shots_fired;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    bit m_valid;
    bit m_locked;
    bit m_prev;
    bit m_shoot;
    int m_wait;
    int m_shots;

    gun_fire_controller #(
        .HEAT_W      (4),
        .HEAT_MAX    (HEAT_MAX),
        .RESUME_LEVEL(RESUME_LEVEL),
        .SHOT_GAP    (SHOT_GAP),
        .GAP_W       (28)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .trigger    (trigger),
        .heat_level (heat_level),
        .spawn_ready(spawn_ready),
        .spawn_valid(spawn_valid),
        .shoot_out  (shoot_out),
        .overheated (overheated),
        .shots_fired(shots_fired)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock of the reference model, using the inputs held across the edge.
    function automatic void model_update();
        bit fire;
        if (reset) begin
            m_valid  = 0;
            m_locked = 0;
            m_prev   = 0;
            m_shoot  = 0;
            m_wait   = 0;
            m_shots  = 0;
            return;
        end
`ifdef GUN_AUTOFIRE_EN
        fire = trigger;
`else
        fire = trigger && !m_prev;
`endif
        if (m_valid) begin
            if (spawn_ready) begin
                m_valid = 0;
                m_wait  = SHOT_GAP;
                if (m_shots < 255) m_shots++;
            end
        end else if (m_wait > 0) begin
            if (m_wait == 1 && int'(heat_level) >= HEAT_MAX) m_locked = 1;
            m_wait--;
        end else if (m_locked) begin
            if (int'(heat_level) <= RESUME_LEVEL) m_locked = 0;
        end else if (int'(heat_level) >= HEAT_MAX) begin
            m_locked = 1;
        end else if (fire) begin
            m_valid = 1;
        end
        m_shoot = trigger && !m_locked;
        m_prev  = trigger;
    endfunction

    task automatic step();
        @(posedge clock);
        model_update();
        #1;
        check("spawn_valid", 32'(spawn_valid), 32'(m_valid));
        check("shoot_out",   32'(shoot_out),   32'(m_shoot));
        check("overheated",  32'(overheated),  32'(m_locked));
        check("shots_fired", 32'(shots_fired), 32'(m_shots));
    endtask

    int valid_cycles;
    int spawn_count;
    int last_rise;
    int r;
    bit prev_valid;

    initial begin
        // 1: reset held with trigger high
        reset       = 1'b1;
        trigger     = 1'b1;
        heat_level  = 4'd0;
        spawn_ready = 1'b0;
        repeat (3) step();
        check("reset_valid", 32'(spawn_valid), 32'd0);
        check("reset_shots", 32'(shots_fired), 32'd0);

        // 2: single pulse, ready high
        reset       = 1'b0;
        trigger     = 1'b0;
        heat_level  = 4'd2;
        spawn_ready = 1'b1;
        step();
        trigger = 1'b1;
        step();
        trigger = 1'b0;
        valid_cycles = 32'(spawn_valid);
        repeat (8) begin
            step();
            valid_cycles += 32'(spawn_valid);
        end
        check("pulse_valid_cycles", 32'(valid_cycles), 32'd1);
        check("pulse_shots", 32'(shots_fired), 32'd1);

        // 3: valid held through 5 not-ready cycles despite trigger release
        spawn_ready = 1'b0;
        trigger     = 1'b1;
        step();
        trigger = 1'b0;
        valid_cycles = 0;
        repeat (5) begin
            step();
            valid_cycles += 32'(spawn_valid);
        end
        check("hold_valid_cycles", 32'(valid_cycles), 32'd5);
        spawn_ready = 1'b1;
        step();
        check("hold_shots", 32'(shots_fired), 32'd2);
        repeat (6) step();

        // 4: overheat lockout and hysteresis
        heat_level = 4'd15;
        trigger    = 1'b1;
        repeat (3) step();
        check("lock_overheated", 32'(overheated), 32'd1);
        check("lock_shoot", 32'(shoot_out), 32'd0);
        heat_level = 4'd5;
        repeat (3) step();
        check("lock_heat5", 32'(overheated), 32'd1);
        heat_level = 4'd4;
        step();
        check("unlock_heat4", 32'(overheated), 32'd0);
        trigger    = 1'b0;
        heat_level = 4'd0;
        repeat (2) step();

        // 5: trigger held with ready high
        trigger     = 1'b1;
        spawn_ready = 1'b1;
        spawn_count = 0;
        last_rise   = -1;
        prev_valid  = 1'b0;
        for (int c = 1; c <= 18; c++) begin
            step();
            if (spawn_valid && !prev_valid) begin
                spawn_count++;
                if (last_rise >= 0) check("autofire_spacing", 32'(c - last_rise), 32'(SHOT_GAP + 2));
                last_rise = c;
            end
            prev_valid = spawn_valid;
        end
`ifdef GUN_AUTOFIRE_EN
        check("held_spawns", 32'(spawn_count), 32'd3);
`else
        check("held_spawns", 32'(spawn_count), 32'd1);
`endif
        trigger = 1'b0;
        repeat (6) step();

        // 6: saturation of shots_fired
        for (int c = 0; c < 2100; c++) begin
            trigger = c[0];
            step();
        end
        check("shots_saturated", 32'(shots_fired), 32'd255);
        trigger = 1'b0;
        repeat (8) step();

        // 6b: reset during a pending spawn
        spawn_ready = 1'b0;
        trigger     = 1'b1;
        repeat (2) step();
        check("pre_reset_valid", 32'(spawn_valid), 32'd1);
        reset = 1'b1;
        step();
        check("mid_reset_valid", 32'(spawn_valid), 32'd0);
        check("mid_reset_shots", 32'(shots_fired), 32'd0);
        reset   = 1'b0;
        trigger = 1'b0;
        step();

        // Randomised run against the model
        for (int c = 0; c < 3000; c++) begin
            reset       = ($urandom_range(0, 199) == 0);
            trigger     = 1'($urandom_range(0, 1));
            spawn_ready = ($urandom_range(0, 2) != 0);
            r           = int'($urandom_range(0, 9));
            if (r < 2)      heat_level = 4'd15;
            else if (r < 4) heat_level = 4'($urandom_range(3, 6));
            else            heat_level = 4'($urandom_range(0, 14));
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
